// File: rtl/gf_audio_pkg.sv
// Shared constants for the gf audio stream: header byte values, header length and
// depacketizer state encodings, also used by axis_dac and the host tooling.
package gf_audio_pkg;

    localparam logic [7:0] MAGIC     = 8'hA5;
    localparam logic [7:0] FORMAT    = 8'h01;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } depkt_state_t;

endpackage

// File: rtl/axis_audio_depacketizer.sv
// Strips and validates the 4-byte audio header on each UDP payload frame and forwards
// the samples through a single output register; bad frames are dropped whole.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_HDR     | consuming header bytes 0..3 (hdr_idx), nothing forwarded
// ST_PAYLOAD | forwarding samples through the output register until tlast
// ST_DROP    | header rejected, discarding bytes until tlast
module axis_audio_depacketizer
    import gf_audio_pkg::*;
#(
    parameter logic [7:0] MAGIC     = gf_audio_pkg::MAGIC,
    parameter logic [7:0] FORMAT    = gf_audio_pkg::FORMAT,
    parameter int         SEQ_WIDTH = 16,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] stat_frames_ok,
    output logic [CNT_WIDTH-1:0] stat_frames_dropped,
    output logic                 stat_seq_gap
);

    localparam logic [1:0] LAST_HDR_IDX = 2'(HDR_BYTES - 1);

    depkt_state_t         state;
    logic [1:0]           hdr_idx;
    logic [7:0]           seq_hi;
    logic [SEQ_WIDTH-1:0] exp_seq;
    logic [SEQ_WIDTH-1:0] rx_seq;
    logic                 seq_valid;
    logic                 s_fire;
    logic                 hdr_bad;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Payload can accept whenever the output register is empty or draining this cycle.
    assign s_axis_tready = (state == ST_PAYLOAD) ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign rx_seq        = SEQ_WIDTH'({seq_hi, s_axis_tdata});
    assign hdr_bad       = ((hdr_idx == 2'd0) && (s_axis_tdata != MAGIC)) ||
                           ((hdr_idx == 2'd1) && (s_axis_tdata != FORMAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_HDR;
            hdr_idx             <= 2'd0;
            seq_hi              <= 8'd0;
            exp_seq             <= '0;
            seq_valid           <= 1'b0;
            m_axis_tdata        <= 8'd0;
            m_axis_tvalid       <= 1'b0;
            m_axis_tlast        <= 1'b0;
            m_axis_tuser        <= 1'b0;
            stat_frames_ok      <= '0;
            stat_frames_dropped <= '0;
            stat_seq_gap        <= 1'b0;
        end else begin
            stat_seq_gap <= 1'b0;
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                ST_HDR: begin
                    if (s_fire) begin
                        if (hdr_bad) begin
                            hdr_idx <= 2'd0;
                            if (s_axis_tlast) begin
                                stat_frames_dropped <= sat_inc(stat_frames_dropped);
                            end else begin
                                state <= ST_DROP;
                            end
                        end else if (hdr_idx == LAST_HDR_IDX) begin
                            hdr_idx      <= 2'd0;
                            stat_seq_gap <= seq_valid && (rx_seq != exp_seq);
                            exp_seq      <= rx_seq + 1'b1;
                            seq_valid    <= 1'b1;
                            if (s_axis_tlast) begin
                                stat_frames_ok <= sat_inc(stat_frames_ok);
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end else if (s_axis_tlast) begin
                            hdr_idx             <= 2'd0;
                            stat_frames_dropped <= sat_inc(stat_frames_dropped);
                        end else begin
                            if (hdr_idx == 2'd2) begin
                                seq_hi <= s_axis_tdata;
                            end
                            hdr_idx <= hdr_idx + 2'd1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (s_fire) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tuser  <= s_axis_tuser;
                        m_axis_tvalid <= 1'b1;
                        if (s_axis_tlast) begin
                            state <= ST_HDR;
                            if (s_axis_tuser) begin
                                stat_frames_dropped <= sat_inc(stat_frames_dropped);
                            end else begin
                                stat_frames_ok <= sat_inc(stat_frames_ok);
                            end
                        end
                    end
                end

                ST_DROP: begin
                    if (s_fire && s_axis_tlast) begin
                        state               <= ST_HDR;
                        stat_frames_dropped <= sat_inc(stat_frames_dropped);
                    end
                end

                default: begin
                    state   <= ST_HDR;
                    hdr_idx <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_audio_depacketizer.sv
// Directed bench for axis_audio_depacketizer: frames are driven byte by byte and the
// forwarded beats, counters and seq-gap pulses are compared against hand-derived values.
module tb_axis_audio_depacketizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;
    logic        seq_gap;

    axis_audio_depacketizer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_tdata        (s_tdata),
        .s_axis_tvalid       (s_tvalid),
        .s_axis_tready       (s_tready),
        .s_axis_tlast        (s_tlast),
        .s_axis_tuser        (s_tuser),
        .m_axis_tdata        (m_tdata),
        .m_axis_tvalid       (m_tvalid),
        .m_axis_tready       (m_tready),
        .m_axis_tlast        (m_tlast),
        .m_axis_tuser        (m_tuser),
        .stat_frames_ok      (frames_ok),
        .stat_frames_dropped (frames_dropped),
        .stat_seq_gap        (seq_gap)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mode = 0;          // 0: m_tready=1, 1: toggle 1010, 2: m_tready=0
    logic [9:0] rx_q[$];           // {tuser, tlast, tdata}
    logic [7:0] frm[$];
    int         gap_cnt = 0;
    int         gap_cyc = -1;
    int         fire_cyc = -1;
    int         hdr3_cyc = -1;
    int         vld_cnt = 0;
    int         stall_viol = 0;
    logic       in_fire = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    // One clock: called just after a negedge, observes the settled signals, then advances.
    task automatic cycle();
        m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'b0;
        #1;
        in_fire = s_tvalid && s_tready;
        if (in_fire) fire_cyc = cyc;
        if (m_tvalid) vld_cnt++;
        if (m_tvalid && m_tready) rx_q.push_back({m_tuser, m_tlast, m_tdata});
        if (seq_gap) begin
            gap_cnt++;
            gap_cyc = cyc;
        end
        if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) stall_viol++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!in_fire && n < 64);
        if (!in_fire) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte %h not accepted within 64 cycles", d);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic user);
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i], i == frm.size() - 1, user && (i == frm.size() - 1));
            if (i == 3) hdr3_cyc = fire_cyc;
        end
    endtask

    task automatic drain();
        int n;
        s_tvalid = 1'b0;
        mode = 0;
        n = 0;
        while (n < 40 && (m_tvalid || n < 3)) begin
            cycle();
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        rx_q.delete();
        gap_cnt = 0;
        vld_cnt = 0;
    endtask

    task automatic test_reset();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        checks++; if (m_tdata !== 8'h00 || m_tlast !== 1'b0 || m_tuser !== 1'b0) begin errors++; $display("FAIL reset_m_data got %h/%b/%b want 00/0/0", m_tdata, m_tlast, m_tuser); end
        checks++; if (frames_ok !== 16'd0 || frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", frames_ok, frames_dropped); end
        checks++; if (s_tready !== 1'b1 || seq_gap !== 1'b0) begin errors++; $display("FAIL reset_ready_gap got %b/%b want 1/0", s_tready, seq_gap); end
    endtask

    task automatic test_basic();
        frm = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h10, 8'h20, 8'h30};
        send_frame(1'b0);
        drain();
        checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL basic_beats got %0d want 3", rx_q.size()); end
        if (rx_q.size() == 3) begin
            checks++; if (rx_q[0] !== 10'h010 || rx_q[1] !== 10'h020 || rx_q[2] !== 10'h130) begin errors++; $display("FAIL basic_data got %h %h %h want 010 020 130", rx_q[0], rx_q[1], rx_q[2]); end
        end
        checks++; if (frames_ok !== 16'd1 || frames_dropped !== 16'd0) begin errors++; $display("FAIL basic_counters got %0d/%0d want 1/0", frames_ok, frames_dropped); end
        checks++; if (gap_cnt !== 0) begin errors++; $display("FAIL basic_gap got %0d want 0", gap_cnt); end
    endtask

    task automatic test_seq_gap();
        int g;
        apply_reset();
        frm = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h01, 8'h02};
        send_frame(1'b0);
        frm = '{8'hA5, 8'h01, 8'h00, 8'h09, 8'h03, 8'h04};
        send_frame(1'b0);
        drain();
        checks++; if (gap_cnt !== 1) begin errors++; $display("FAIL seq_gap_count got %0d want 1", gap_cnt); end
        checks++; if (gap_cyc !== hdr3_cyc + 1) begin errors++; $display("FAIL seq_gap_timing got cycle %0d want %0d", gap_cyc, hdr3_cyc + 1); end
        checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL seq_gap_payload got %0d beats want 4", rx_q.size()); end
        frm = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h05};
        send_frame(1'b0);
        drain();
        g = gap_cnt;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h06};
        send_frame(1'b0);
        drain();
        checks++; if (gap_cnt !== g) begin errors++; $display("FAIL seq_wrap_gap got %0d pulses want %0d", gap_cnt, g); end
        checks++; if (frames_ok !== 16'd4 || frames_dropped !== 16'd0) begin errors++; $display("FAIL seq_counters got %0d/%0d want 4/0", frames_ok, frames_dropped); end
    endtask

    task automatic test_bad_header();
        int v;
        int g;
        rx_q.delete();
        v = vld_cnt;
        g = gap_cnt;
        frm = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_frame(1'b0);
        drain();
        checks++; if (vld_cnt !== v) begin errors++; $display("FAIL bad_magic_valid got %0d valid cycles want %0d", vld_cnt, v); end
        checks++; if (frames_dropped !== 16'd1) begin errors++; $display("FAIL bad_magic_dropped got %0d want 1", frames_dropped); end
        frm = '{8'hA5, 8'h02};
        send_frame(1'b0);
        frm = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hCC};
        send_frame(1'b0);
        drain();
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 10'h1CC) begin errors++; $display("FAIL bad_hdr_recover got %0d beats first %h want 1 beat 1cc", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 10'h0); end
        checks++; if (frames_dropped !== 16'd2 || frames_ok !== 16'd5) begin errors++; $display("FAIL bad_hdr_counters got %0d/%0d want ok 5 dropped 2", frames_ok, frames_dropped); end
        checks++; if (gap_cnt !== g) begin errors++; $display("FAIL bad_hdr_gap got %0d want %0d", gap_cnt, g); end
    endtask

    task automatic test_short();
        int v;
        v = vld_cnt;
        frm = '{8'hA5, 8'h01};
        send_frame(1'b0);
        checks++; if (frames_dropped !== 16'd3) begin errors++; $display("FAIL short_dropped got %0d want 3", frames_dropped); end
        frm = '{8'hA5, 8'h01, 8'h00, 8'h02};
        send_frame(1'b0);
        drain();
        checks++; if (frames_ok !== 16'd6) begin errors++; $display("FAIL zero_len_ok got %0d want 6", frames_ok); end
        checks++; if (vld_cnt !== v) begin errors++; $display("FAIL zero_len_beats got %0d valid cycles want %0d", vld_cnt, v); end
    endtask

    task automatic test_stall();
        int bad;
        rx_q.delete();
        stall_viol = 0;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h0A};
        for (int i = 0; i < 16; i++) frm.push_back(8'h40 + 8'(i));
        mode = 1;
        send_frame(1'b0);
        drain();
        checks++; if (rx_q.size() !== 16) begin errors++; $display("FAIL stall_beats got %0d want 16", rx_q.size()); end
        bad = 0;
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            if (rx_q[i] !== {1'b0, (i == 15), 8'h40 + 8'(i)}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order got %0d wrong beats want 0", bad); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes while stalled want 0", stall_viol); end
        checks++; if (frames_ok !== 16'd7) begin errors++; $display("FAIL stall_ok got %0d want 7", frames_ok); end
    endtask

    task automatic test_reset_mid();
        int v;
        mode = 0;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h22) begin errors++; $display("FAIL mid_pre got %b/%h want 1/22", m_tvalid, m_tdata); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", m_tvalid); end
        checks++; if (frames_ok !== 16'd0 || frames_dropped !== 16'd0) begin errors++; $display("FAIL mid_async_counters got %0d/%0d want 0/0", frames_ok, frames_dropped); end
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        v = vld_cnt;
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        drain();
        checks++; if (frames_dropped !== 16'd1 || vld_cnt !== v) begin errors++; $display("FAIL mid_resync got dropped %0d valid %0d want 1 and %0d", frames_dropped, vld_cnt, v); end
        frm = '{8'hA5, 8'h01, 8'h00, 8'h04, 8'h55, 8'h66};
        send_frame(1'b1);
        drain();
        checks++; if (rx_q.size() !== 2 || rx_q[1] !== 10'h366 || rx_q[0] !== 10'h055) begin errors++; $display("FAIL tuser_beats got %0d beats want 055 366", rx_q.size()); end
        checks++; if (frames_dropped !== 16'd2 || frames_ok !== 16'd0) begin errors++; $display("FAIL tuser_counters got ok %0d dropped %0d want 0/2", frames_ok, frames_dropped); end
    endtask

    initial begin
        @(negedge clk);
        repeat (3) cycle();
        test_reset();
        rst_n = 1'b1;
        cycle();
        test_reset();
        test_basic();
        test_seq_gap();
        test_bad_header();
        test_short();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
